// File: rtl/cb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// cb_wb_arbiter
//
// Writeback arbiter between the execution-stage functional units and the
// completion buffer result-write ports. Up to NUM_WPORTS valid results are
// granted per cycle in rotating priority. Each granted result is registered
// onto its own write port, so the buffer needs only NUM_WPORTS write ports.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   flush                kills all in-flight results (exception at head)
//   req_valid/req_ready  per-requester handshake (ready is combinational)
//   req_index/data/vd    per-requester payload, requester i in slice i
//   req_wen/exc/mal      per-requester flags
//   wp_*                 registered completion buffer write ports
//   conflict             registered pulse: same-cycle grants hit one index
//   rr_ptr_o             current highest-priority requester (debug)
// -----------------------------------------------------------------------------
module cb_wb_arbiter #(
    parameter int NUM_REQ    = 5,
    parameter int NUM_WPORTS = 2,
    parameter int NUM_ENTRY  = 16,
    parameter int IDX_W      = $clog2(NUM_ENTRY),
    parameter int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*IDX_W-1:0]      req_index,
    input  logic [NUM_REQ*32-1:0]         req_data,
    input  logic [NUM_REQ*5-1:0]          req_vd,
    input  logic [NUM_REQ-1:0]            req_wen,
    input  logic [NUM_REQ-1:0]            req_exc,
    input  logic [NUM_REQ-1:0]            req_mal,
    output logic [NUM_WPORTS-1:0]         wp_valid,
    output logic [NUM_WPORTS*IDX_W-1:0]   wp_index,
    output logic [NUM_WPORTS*32-1:0]      wp_data,
    output logic [NUM_WPORTS*5-1:0]       wp_vd,
    output logic [NUM_WPORTS-1:0]         wp_wen,
    output logic [NUM_WPORTS-1:0]         wp_exc,
    output logic [NUM_WPORTS-1:0]         wp_mal,
    output logic                          conflict,
    output logic [PTR_W-1:0]              rr_ptr_o
);

    // Registered state
    logic [PTR_W-1:0]              rr_ptr_q,   rr_ptr_d;
    logic [NUM_WPORTS-1:0]         wp_valid_q, wp_valid_d;
    logic [NUM_WPORTS*IDX_W-1:0]   wp_index_q, wp_index_d;
    logic [NUM_WPORTS*32-1:0]      wp_data_q,  wp_data_d;
    logic [NUM_WPORTS*5-1:0]       wp_vd_q,    wp_vd_d;
    logic [NUM_WPORTS-1:0]         wp_wen_q,   wp_wen_d;
    logic [NUM_WPORTS-1:0]         wp_exc_q,   wp_exc_d;
    logic [NUM_WPORTS-1:0]         wp_mal_q,   wp_mal_d;
    logic                          conflict_q, conflict_d;

    // Arbitration results
    logic [NUM_REQ-1:0]                   grant_s;
    logic [NUM_WPORTS-1:0][PTR_W-1:0]     sel_s;      // requester on port k
    logic [NUM_WPORTS-1:0]                sel_vld_s;  // port k has a grant
    logic [PTR_W-1:0]                     last_s;     // last granted requester
    logic                                 any_s;

    // Rotating-priority scan: first NUM_WPORTS valid requesters from rr_ptr.
    // Depends only on req_valid, flush and rr_ptr, never on payload.
    always_comb begin
        int cnt;
        int idx;
        cnt       = 0;
        idx       = 0;
        grant_s   = '0;
        sel_s     = '0;
        sel_vld_s = '0;
        last_s    = '0;
        any_s     = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = (int'(rr_ptr_q) + j) % NUM_REQ;
            if (!flush && req_valid[idx] && (cnt < NUM_WPORTS)) begin
                grant_s[idx]   = 1'b1;
                sel_s[cnt]     = PTR_W'(idx);
                sel_vld_s[cnt] = 1'b1;
                last_s         = PTR_W'(idx);
                any_s          = 1'b1;
                cnt            = cnt + 1;
            end else begin
                // not granted this cycle: defaults stand
            end
        end
    end

    assign req_ready = grant_s;

    // Port payload mux, collision detect and next priority pointer
    always_comb begin
        wp_valid_d = '0;
        wp_index_d = '0;
        wp_data_d  = '0;
        wp_vd_d    = '0;
        wp_wen_d   = '0;
        wp_exc_d   = '0;
        wp_mal_d   = '0;
        conflict_d = 1'b0;
        rr_ptr_d   = rr_ptr_q;

        for (int k = 0; k < NUM_WPORTS; k++) begin
            if (sel_vld_s[k]) begin
                wp_valid_d[k]               = 1'b1;
                wp_index_d[k*IDX_W +: IDX_W] = req_index[int'(sel_s[k])*IDX_W +: IDX_W];
                wp_data_d[k*32 +: 32]        = req_data[int'(sel_s[k])*32 +: 32];
                wp_vd_d[k*5 +: 5]            = req_vd[int'(sel_s[k])*5 +: 5];
                // an excepting result must never write the register file
                wp_wen_d[k]                 = req_wen[sel_s[k]] & ~req_exc[sel_s[k]];
                wp_exc_d[k]                 = req_exc[sel_s[k]];
                wp_mal_d[k]                 = req_mal[sel_s[k]];
            end else begin
                wp_valid_d[k] = 1'b0;
            end
        end

        // Any two live ports aimed at the same entry is a design error upstream
        for (int a = 0; a < NUM_WPORTS; a++) begin
            for (int b = a + 1; b < NUM_WPORTS; b++) begin
                if (sel_vld_s[a] && sel_vld_s[b] &&
                    (wp_index_d[a*IDX_W +: IDX_W] == wp_index_d[b*IDX_W +: IDX_W])) begin
                    conflict_d = 1'b1;
                end else begin
                    // no collision between this pair
                end
            end
        end

        // Priority resumes just past the last winner; wraps at NUM_REQ, which
        // need not be a power of two.
        if (flush) begin
            rr_ptr_d = '0;
        end else if (any_s) begin
            if (last_s == PTR_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = last_s + PTR_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State and output registers, cleared asynchronously on reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_q   <= '0;
            wp_valid_q <= '0;
            wp_index_q <= '0;
            wp_data_q  <= '0;
            wp_vd_q    <= '0;
            wp_wen_q   <= '0;
            wp_exc_q   <= '0;
            wp_mal_q   <= '0;
            conflict_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wp_valid_q <= wp_valid_d;
            wp_index_q <= wp_index_d;
            wp_data_q  <= wp_data_d;
            wp_vd_q    <= wp_vd_d;
            wp_wen_q   <= wp_wen_d;
            wp_exc_q   <= wp_exc_d;
            wp_mal_q   <= wp_mal_d;
            conflict_q <= conflict_d;
        end
    end

    assign wp_valid = wp_valid_q;
    assign wp_index = wp_index_q;
    assign wp_data  = wp_data_q;
    assign wp_vd    = wp_vd_q;
    assign wp_wen   = wp_wen_q;
    assign wp_exc   = wp_exc_q;
    assign wp_mal   = wp_mal_q;
    assign conflict = conflict_q;
    assign rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_cb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cb_wb_arbiter
//
// Directed bench for cb_wb_arbiter at default parameters. A queue-based
// reference model checks every output on every falling edge; directed steps
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_cb_wb_arbiter;

    localparam int NR = 5;
    localparam int NW = 2;
    localparam int IW = 4;

    logic           CLK;
    logic           nRST;
    logic           flush;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [NR*IW-1:0] req_index;
    logic [NR*32-1:0] req_data;
    logic [NR*5-1:0]  req_vd;
    logic [NR-1:0]  req_wen;
    logic [NR-1:0]  req_exc;
    logic [NR-1:0]  req_mal;
    logic [NW-1:0]  wp_valid;
    logic [NW*IW-1:0] wp_index;
    logic [NW*32-1:0] wp_data;
    logic [NW*5-1:0]  wp_vd;
    logic [NW-1:0]  wp_wen;
    logic [NW-1:0]  wp_exc;
    logic [NW-1:0]  wp_mal;
    logic           conflict;
    logic [2:0]     rr_ptr_o;

    // per-requester payload as seen by the bench
    logic [IW-1:0]  v_idx  [NR];
    logic [31:0]    v_data [NR];
    logic [4:0]     v_vd   [NR];
    logic           v_wen  [NR];
    logic           v_exc  [NR];
    logic           v_mal  [NR];

    int total = 0;
    int bad   = 0;

    cb_wb_arbiter dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_data(req_data), .req_vd(req_vd),
        .req_wen(req_wen), .req_exc(req_exc), .req_mal(req_mal),
        .wp_valid(wp_valid), .wp_index(wp_index), .wp_data(wp_data),
        .wp_vd(wp_vd), .wp_wen(wp_wen), .wp_exc(wp_exc), .wp_mal(wp_mal),
        .conflict(conflict), .rr_ptr_o(rr_ptr_o)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always_comb begin
        req_index = '0;
        req_data  = '0;
        req_vd    = '0;
        req_wen   = '0;
        req_exc   = '0;
        req_mal   = '0;
        for (int i = 0; i < NR; i++) begin
            req_index[i*IW +: IW] = v_idx[i];
            req_data[i*32 +: 32]  = v_data[i];
            req_vd[i*5 +: 5]      = v_vd[i];
            req_wen[i]            = v_wen[i];
            req_exc[i]            = v_exc[i];
            req_mal[i]            = v_mal[i];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_ptr;
    int            m_order[$];
    logic [NR-1:0] m_ready;
    logic [NW-1:0] e_valid, e_wen, e_exc, e_mal;
    logic [NW*IW-1:0] e_index;
    logic [NW*32-1:0] e_data;
    logic [NW*5-1:0]  e_vd;
    logic          e_conf;

    always @(negedge CLK) begin
        if (!nRST) begin
            m_ptr   = 0;
            e_valid = '0; e_wen = '0; e_exc = '0; e_mal = '0;
            e_index = '0; e_data = '0; e_vd = '0; e_conf = 1'b0;
        end
        // winners this cycle: the first NW valid requesters walking from m_ptr
        m_order = {};
        if (!flush) begin
            for (int j = 0; j < NR; j++) begin
                if (req_valid[(m_ptr + j) % NR] && m_order.size() < NW)
                    m_order.push_back((m_ptr + j) % NR);
            end
        end
        m_ready = '0;
        foreach (m_order[q]) m_ready[m_order[q]] = 1'b1;

        chk("ready",    req_ready, m_ready);
        chk("rr_ptr",   rr_ptr_o,  m_ptr[2:0]);
        chk("wp_valid", wp_valid,  e_valid);
        chk("wp_index", wp_index,  e_index);
        chk("wp_data",  wp_data,   e_data);
        chk("wp_vd",    wp_vd,     e_vd);
        chk("wp_wen",   wp_wen,    e_wen);
        chk("wp_exc",   wp_exc,    e_exc);
        chk("wp_mal",   wp_mal,    e_mal);
        chk("conflict", conflict,  e_conf);

        if (nRST) begin
            e_valid = '0; e_wen = '0; e_exc = '0; e_mal = '0;
            e_index = '0; e_data = '0; e_vd = '0; e_conf = 1'b0;
            foreach (m_order[q]) begin
                e_valid[q]           = 1'b1;
                e_index[q*IW +: IW]  = v_idx[m_order[q]];
                e_data[q*32 +: 32]   = v_data[m_order[q]];
                e_vd[q*5 +: 5]       = v_vd[m_order[q]];
                e_wen[q]             = v_wen[m_order[q]] && !v_exc[m_order[q]];
                e_exc[q]             = v_exc[m_order[q]];
                e_mal[q]             = v_mal[m_order[q]];
            end
            for (int a = 0; a < m_order.size(); a++)
                for (int b = a + 1; b < m_order.size(); b++)
                    if (v_idx[m_order[a]] == v_idx[m_order[b]]) e_conf = 1'b1;
            if (flush)                 m_ptr = 0;
            else if (m_order.size() > 0) m_ptr = (m_order[m_order.size()-1] + 1) % NR;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST  = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < NR; i++) begin
            v_idx[i]  = 4'(i + 8);
            v_data[i] = 32'hA000_0000 + 32'(i);
            v_vd[i]   = 5'(i + 1);
            v_wen[i]  = 1'b1;
            v_exc[i]  = 1'b0;
            v_mal[i]  = 1'b0;
        end
        req_valid = 5'b11111;

        // reset state: pointer 0 so requesters 0 and 1 are ready
        repeat (2) @(negedge CLK);
        chk("rst_rr",       rr_ptr_o,  3'd0);
        chk("rst_wp_valid", wp_valid,  2'b00);
        chk("rst_conflict", conflict,  1'b0);
        chk("rst_ready",    req_ready, 5'b00011);

        // D1: single arith result
        step();
        nRST = 1'b1;
        req_valid = 5'b00001;
        v_idx[0] = 4'd3; v_data[0] = 32'hDEADBEEF;
        @(negedge CLK);
        chk("d1_ready", req_ready, 5'b00001);
        step();
        req_valid = 5'b00000;
        @(negedge CLK);
        chk("d1_wp_valid", wp_valid,      2'b01);
        chk("d1_wp_index", wp_index[3:0], 4'd3);
        chk("d1_wp_data",  wp_data[31:0], 32'hDEADBEEF);
        chk("d1_wp_wen",   wp_wen[0],     1'b1);
        chk("d1_rr",       rr_ptr_o,      3'd1);

        // D2: all valid from pointer 0 -> {0,1} {2,3} {4,0}
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        req_valid = 5'b11111;
        @(negedge CLK);
        chk("d2_ready0", req_ready, 5'b00011);
        chk("d2_rr0",    rr_ptr_o,  3'd0);
        step();
        @(negedge CLK);
        chk("d2_ready1", req_ready, 5'b01100);
        chk("d2_rr1",    rr_ptr_o,  3'd2);
        step();
        @(negedge CLK);
        chk("d2_ready2", req_ready, 5'b10001);
        chk("d2_rr2",    rr_ptr_o,  3'd4);
        step();
        req_valid = 5'b00000;
        @(negedge CLK);
        chk("d2_rr3",        rr_ptr_o,      3'd1);
        chk("d2_wp_valid",   wp_valid,      2'b11);
        chk("d2_wp0_index",  wp_index[3:0], 4'd12);
        chk("d2_wp1_index",  wp_index[7:4], 4'd3);

        // D3: walk pointer to 4, then valid {1,4} -> 4 on port 0, 1 on port 1
        step();
        req_valid = 5'b01110;
        step();
        req_valid = 5'b01000;
        step();
        req_valid = 5'b10010;
        @(negedge CLK);
        chk("d3_rr_before", rr_ptr_o,  3'd4);
        chk("d3_ready",     req_ready, 5'b10010);
        step();
        req_valid = 5'b00000;
        @(negedge CLK);
        chk("d3_wp_valid",  wp_valid,        2'b11);
        chk("d3_wp0_index", wp_index[3:0],   4'd12);
        chk("d3_wp1_index", wp_index[7:4],   4'd9);
        chk("d3_wp0_data",  wp_data[31:0],   32'hA000_0004);
        chk("d3_wp1_vd",    wp_vd[9:5],      5'd2);
        chk("d3_rr",        rr_ptr_o,        3'd2);

        // D4: ls with exception and misalignment
        step();
        v_exc[3] = 1'b1; v_mal[3] = 1'b1; v_wen[3] = 1'b1;
        req_valid = 5'b01000;
        step();
        req_valid = 5'b00000;
        @(negedge CLK);
        chk("d4_wp_valid", wp_valid, 2'b01);
        chk("d4_wp_exc",   wp_exc,   2'b01);
        chk("d4_wp_wen",   wp_wen,   2'b00);
        chk("d4_wp_mal",   wp_mal,   2'b01);
        chk("d4_rr",       rr_ptr_o, 3'd4);
        v_exc[3] = 1'b0; v_mal[3] = 1'b0;

        // D5: flush with everything valid
        step();
        req_valid = 5'b11111;
        flush = 1'b1;
        @(negedge CLK);
        chk("d5_ready_flush", req_ready, 5'b00000);
        step();
        flush = 1'b0;
        @(negedge CLK);
        chk("d5_wp_valid", wp_valid,  2'b00);
        chk("d5_rr",       rr_ptr_o,  3'd0);
        chk("d5_ready",    req_ready, 5'b00011);
        step();
        @(negedge CLK);
        chk("d5_wp_resume", wp_valid, 2'b11);
        chk("d5_rr_resume", rr_ptr_o, 3'd2);

        // D6: mul and div to the same entry, then to different entries
        step();
        req_valid = 5'b00110;
        v_idx[1] = 4'd7; v_idx[2] = 4'd7;
        @(negedge CLK);
        chk("d6_ready", req_ready, 5'b00110);
        step();
        v_idx[2] = 4'd8;
        @(negedge CLK);
        chk("d6_conflict",  conflict, 1'b1);
        chk("d6_wp_valid",  wp_valid, 2'b11);
        chk("d6_wp_index",  wp_index, 8'h77);
        step();
        req_valid = 5'b00000;
        @(negedge CLK);
        chk("d6_noconf",    conflict, 1'b0);
        chk("d6_wp_valid2", wp_valid, 2'b11);
        step();
        @(negedge CLK);
        chk("d6_noconf2",   conflict, 1'b0);
        chk("d6_idle",      wp_valid, 2'b00);

        // reset in the middle of traffic
        step();
        req_valid = 5'b11111;
        step();
        nRST = 1'b0;
        @(negedge CLK);
        chk("mr_rr",       rr_ptr_o, 3'd0);
        chk("mr_wp_valid", wp_valid, 2'b00);
        step();
        nRST = 1'b1;
        @(negedge CLK);
        chk("mr_ready", req_ready, 5'b00011);
        step();
        req_valid = 5'b00000;
        step();
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cb_wb_arbiter.md
Name: cb_wb_arbiter

Overview:
- Writeback arbiter between the execution-stage functional units and the completion buffer result-write ports.
- Functional units are arithmetic, multiply, divide, load/store and vector.
- Each unit presents one result per cycle with a valid/ready handshake.
- The block grants up to NUM_WPORTS results per cycle in rotating (round-robin) priority and registers them onto the completion buffer write ports, so the buffer needs only NUM_WPORTS write ports instead of one per unit.

Parameters:
- NUM_REQ, 5: number of functional-unit requesters (0=arith, 1=mul, 2=div, 3=ls, 4=vector).
- NUM_WPORTS, 2: completion buffer write ports; must be ≤ NUM_REQ.
- NUM_ENTRY, 16: completion buffer depth; IDX_W = $clog2(NUM_ENTRY).

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- flush  in  1  completion buffer flush (exception at head); kills all in-flight results.
- req_valid  in  NUM_REQ  result valid per requester.
- req_ready  out  NUM_REQ  grant per requester; combinational.
- req_index  in  NUM_REQ*IDX_W  target entry per requester; requester i occupies slice i.
- req_data  in  NUM_REQ*32  result data.
- req_vd  in  NUM_REQ*5  destination register.
- req_wen  in  NUM_REQ  register write enable.
- req_exc  in  NUM_REQ  exception flag.
- req_mal  in  NUM_REQ  misaligned flag (meaningful for ls only).
- wp_valid  out  NUM_WPORTS  write port k carries a result.
- wp_index  out  NUM_WPORTS*IDX_W  entry to write.
- wp_data  out  NUM_WPORTS*32  data.
- wp_vd  out  NUM_WPORTS*5  destination register.
- wp_wen  out  NUM_WPORTS  write enable, already masked: req_wen & ~req_exc.
- wp_exc  out  NUM_WPORTS  exception.
- wp_mal  out  NUM_WPORTS  misaligned.
- conflict  out  1  pulse: two results granted in the same cycle target the same index.
- rr_ptr_o  out  $clog2(NUM_REQ)  current highest-priority requester (debug).

Behaviour:
- **Reset.** rr_ptr=0. All wp_* = 0, conflict=0. req_ready follows the combinational rule below using rr_ptr=0.
- **Priority order.** Requesters are scanned in order rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ.
- **Grant rule.** req_ready[i]=1 iff ~flush, req_valid[i]=1, and i is among the first NUM_WPORTS valid requesters in priority order.
- **Ready dependencies.** req_ready depends only on req_valid, flush and rr_ptr, never on payload, so there is no combinational loop.
- **Transfer.** A transfer happens when req_valid[i] & req_ready[i]. A requester that is not granted must hold valid and payload stable until granted.
- **Port assignment.** The k-th granted requester in priority order drives write port k. Ports above the grant count have wp_valid=0.
- **Latency.** Exactly 1 cycle: payload granted in cycle t appears on wp_* in cycle t+1 for one cycle only. There are no output stalls, because the completion buffer always accepts writes.
- **rr_ptr update.**
  - If any grant: rr_ptr ← (index of last granted requester + 1) mod NUM_REQ.
  - If no grant: rr_ptr is held.
  - Result: every continuously valid requester is granted within ceil(NUM_REQ/NUM_WPORTS) cycles (3 at defaults).
- **Flush.**
  - In a flush cycle: req_ready=0 for all requesters, and wp_valid ← 0 next cycle.
  - Any output registered in the flush cycle is discarded.
  - rr_ptr ← 0.
  - Requesters drop their own valids on flush; no arbiter action is needed.
- **Collision.** conflict is registered: 1 in cycle t+1 if two results granted in cycle t have equal req_index. Both results are still forwarded, port 0 first; the completion buffer applies port order (higher port wins). This is a design-error indicator for assertions.
- **Width rules.**
  - wp_wen = req_wen & ~req_exc.
  - wp_mal is passed through unchanged.
  - rr_ptr increments modulo NUM_REQ, including non-power-of-2 values (at NUM_REQ=5 it wraps 4→0).
- **Reset mid-operation.** Asynchronous clear of all registers; in-flight results are lost.

Test Plan:
- **Directed 1.** Reset, then valid={arith}, index 3, data 0xDEADBEEF, wen=1 → ready[0]=1 same cycle; next cycle wp_valid=2'b01, wp_index[0]=3, wp_data[0]=0xDEADBEEF, wp_wen[0]=1; rr_ptr=1.
- **Directed 2.** All 5 requesters valid and held for 3 cycles from rr_ptr=0 → grants {0,1}, {2,3}, {4,0}; rr_ptr sequence 0→2→4→1; each requester is granted within 3 cycles.
- **Directed 3.** rr_ptr=4, valid={1,4} → requester 4 on port 0, requester 1 on port 1; rr_ptr becomes 2.
- **Directed 4.** ls valid with exc=1, wen=1, mal=1 → wp_exc=1, wp_wen=0, wp_mal=1.
- **Directed 5.** All requesters valid, flush=1 for one cycle → no ready in that cycle; wp_valid=0 the following cycle; rr_ptr=0; arbitration resumes normally the next cycle.
- **Directed 6.** mul and div both valid, both index 7 → both forwarded next cycle and conflict=1 for exactly one cycle; the same pair with indices 7 and 8 → conflict=0.
